// File: rtl/pulse_stretcher_if.sv
// Tick/level bundle between a tick source and the pulse stretcher.
// The master drives tick and configuration; the slave returns the stretched outputs.
interface pulse_stretcher_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic             retrig;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] holdoff;
  logic             level;
  logic             toggle;
  logic             busy;
  logic             dropped;

  modport master (
    output tick, retrig, width, holdoff,
    input  level, toggle, busy, dropped
  );

  modport slave (
    input  tick, retrig, width, holdoff,
    output level, toggle, busy, dropped
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle ticks into fixed-width levels with an optional low holdoff.
// Every output is a flop, so nothing on the interface is a combinational function of the inputs.
module pulse_stretcher #(
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              reset,
  pulse_stretcher_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_busy;
  logic             r_toggle;
  logic             r_dropped;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_toggle_nxt;
  logic             w_dropped_nxt;

  // The counter holds "cycles remaining minus one", so a load of N-1 yields exactly N cycles.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves it unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_toggle_nxt  = r_toggle;
    w_dropped_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.tick) begin
          if (bus.width != ZERO) begin
            w_state_nxt  = ST_HIGH;
            w_cnt_nxt    = bus.width - ONE;
            w_toggle_nxt = ~r_toggle;
          end else begin
            w_dropped_nxt = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (bus.tick && bus.retrig && (bus.width != ZERO)) begin
          w_cnt_nxt    = bus.width - ONE;
          w_toggle_nxt = ~r_toggle;
        end else begin
          w_dropped_nxt = bus.tick;
          if (r_cnt != ZERO) begin
            w_cnt_nxt = r_cnt - ONE;
          end else if (bus.holdoff == ZERO) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = bus.holdoff - ONE;
          end
        end
      end

      ST_HOLD: begin
        w_dropped_nxt = bus.tick;
        if (r_cnt != ZERO) begin
          w_cnt_nxt = r_cnt - ONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // level/busy are decoded from the next state so they leave a flop in the same cycle as the state.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= ZERO;
      r_level   <= 1'b0;
      r_busy    <= 1'b0;
      r_toggle  <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= (w_state_nxt == ST_HIGH);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_toggle  <= w_toggle_nxt;
      r_dropped <= w_dropped_nxt;
    end
  end

  assign bus.level   = r_level;
  assign bus.busy    = r_busy;
  assign bus.toggle  = r_toggle;
  assign bus.dropped = r_dropped;

endmodule
